// File: rtl/smaesh_hpc_pkg.sv
// smaesh_hpc_pkg: shared scheduler state encoding and default seed/period sizing
package smaesh_hpc_pkg;
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_OFFER = 2'd1,
        ST_IDLE  = 2'd2
    } state_e;
    localparam int DEF_SEED_W = 80;
    localparam int DEF_CNT_W  = 16;
    localparam int DEF_PERIOD = 1024;
endpackage

// File: rtl/smaesh_sat_cnt.sv
// smaesh_sat_cnt: saturating up-counter with synchronous clear taking priority over increment
module smaesh_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) count <= '0;
        else if (clr) count <= '0;
        else if (inc && count != {W{1'b1}}) count <= count + 1'b1;
    end
endmodule

// File: rtl/smaesh_reseed_scheduler.sv
// smaesh_reseed_scheduler: fetches a TRNG seed, hands it to the arbiter, and
// gates data traffic until a fresh seed is delivered every PERIOD blocks.
module smaesh_reseed_scheduler
    import smaesh_hpc_pkg::*;
#(
    parameter int SEED_W = DEF_SEED_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int PERIOD = DEF_PERIOD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trng_seed_valid,
    input  logic [SEED_W-1:0] trng_seed_data,
    output logic              trng_seed_ready,
    output logic              out_seed_valid,
    output logic [SEED_W-1:0] out_seed_data,
    input  logic              out_seed_ready,
    input  logic              aes_blk_done,
    input  logic              force_reseed,
    output logic              data_gate,
    output logic              seeded,
    output logic [CNT_W-1:0]  blk_count
);
    localparam logic [CNT_W-1:0] PER = CNT_W'(PERIOD);

    state_e            state_q, state_d;
    logic [SEED_W-1:0] seed_q;
    logic              rdy_q, vld_q, gate_q, seeded_q;
    logic              trng_hs, out_hs, reseed;
    logic [CNT_W-1:0]  cnt_inc, cnt_d;

    assign trng_hs = trng_seed_valid & rdy_q;
    assign out_hs  = vld_q & out_seed_ready;

    smaesh_sat_cnt #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (aes_blk_done),
        .clr   (out_hs),
        .count (blk_count)
    );

    // Next counter value mirrors the sub-module so the gate can be registered
    always_comb begin
        cnt_inc = (blk_count == {CNT_W{1'b1}}) ? blk_count : blk_count + 1'b1;
        cnt_d   = out_hs ? '0 : aes_blk_done ? cnt_inc : blk_count;
        reseed  = force_reseed || (aes_blk_done && cnt_inc == PER);
        state_d = (state_q == ST_FETCH) ? (trng_hs ? ST_OFFER : ST_FETCH) :
                  (state_q == ST_OFFER) ? (out_hs ? ST_IDLE : ST_OFFER) :
                  (reseed ? ST_FETCH : ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_FETCH;
            seed_q   <= '0;
            rdy_q    <= 1'b1;
            vld_q    <= 1'b0;
            gate_q   <= 1'b1;
            seeded_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            seed_q   <= trng_hs ? trng_seed_data : out_hs ? '0 : seed_q;
            rdy_q    <= state_d == ST_FETCH;
            vld_q    <= state_d == ST_OFFER;
            gate_q   <= state_d != ST_IDLE || cnt_d >= PER;
            seeded_q <= seeded_q | out_hs;
        end
    end

    assign trng_seed_ready = rdy_q;
    assign out_seed_valid  = vld_q;
    assign out_seed_data   = seed_q;
    assign data_gate       = gate_q;
    assign seeded          = seeded_q;
endmodule

// File: tb/tb_smaesh_reseed_scheduler.sv
// tb_smaesh_reseed_scheduler: randomized and directed scoreboard bench for the reseed scheduler
`timescale 1ns/1ps
module tb_smaesh_reseed_scheduler;
    localparam int SW = 80;
    localparam int CW = 16;
    localparam int P  = 4;

    logic          clk = 0, rst = 1;
    logic          tv = 0, orr = 0, done = 0, frc = 0;
    logic [SW-1:0] td = '0;
    logic          tr, ov, gate, sd;
    logic [SW-1:0] od;
    logic [CW-1:0] cnt;

    logic          s_rst = 1, s_tv = 0, s_done = 0;
    logic [SW-1:0] s_td = '0;
    logic          s_tr, s_ov, s_gate, s_sd;
    logic [SW-1:0] s_od;
    logic [2:0]    s_cnt;

    smaesh_reseed_scheduler #(.SEED_W(SW), .CNT_W(CW), .PERIOD(P)) dut (
        .clk(clk), .rst(rst), .trng_seed_valid(tv), .trng_seed_data(td),
        .trng_seed_ready(tr), .out_seed_valid(ov), .out_seed_data(od),
        .out_seed_ready(orr), .aes_blk_done(done), .force_reseed(frc),
        .data_gate(gate), .seeded(sd), .blk_count(cnt)
    );

    smaesh_reseed_scheduler #(.SEED_W(SW), .CNT_W(3), .PERIOD(7)) dut_sat (
        .clk(clk), .rst(s_rst), .trng_seed_valid(s_tv), .trng_seed_data(s_td),
        .trng_seed_ready(s_tr), .out_seed_valid(s_ov), .out_seed_data(s_od),
        .out_seed_ready(1'b0), .aes_blk_done(s_done), .force_reseed(1'b0),
        .data_gate(s_gate), .seeded(s_sd), .blk_count(s_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;

    task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: phase of the seed life cycle plus a plain integer block count
    typedef enum {M_FETCH, M_OFFER, M_IDLE} phase_t;
    phase_t        m_ph = M_FETCH;
    int            m_cnt = 0, m_nxt;
    bit            m_seeded = 0;
    logic [SW-1:0] exp_q[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph = M_FETCH;
            m_cnt = 0;
            m_seeded = 0;
            exp_q.delete();
        end else begin
            m_nxt = (done && m_cnt < (1 << CW) - 1) ? m_cnt + 1 : m_cnt;
            case (m_ph)
                M_FETCH: if (tv) begin exp_q.push_back(td); m_ph = M_OFFER; end
                M_OFFER: if (orr) begin m_ph = M_IDLE; m_nxt = 0; m_seeded = 1; end
                default: if (frc || (done && m_nxt == P)) m_ph = M_FETCH;
            endcase
            m_cnt = m_nxt;
        end
    end

    // Monitor: compares status every cycle and pops the seed scoreboard on delivery
    always @(negedge clk) begin
        check("trng_ready", SW'(tr), SW'(m_ph == M_FETCH));
        check("out_valid", SW'(ov), SW'(m_ph == M_OFFER));
        check("data_gate", SW'(gate), SW'(m_ph != M_IDLE || m_cnt >= P));
        check("seeded", SW'(sd), SW'(m_seeded));
        check("blk_count", SW'(cnt), SW'(m_cnt));
        if (ov) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_seed: got %0h expected no offer at %0t", od, $time);
            end else begin
                check("out_seed", od, exp_q[0]);
                if (orr) void'(exp_q.pop_front());
            end
        end else begin
            check("seed_zero", od, '0);
        end
    end

    initial begin
        repeat (3) step();
        rst = 0;
        s_rst = 0;
        step();
        // First seed delivery
        tv = 1;
        td = 80'h0123456789ABCDEF0011;
        step();
        tv = 0;
        td = '0;
        step();
        orr = 1;
        step();
        orr = 0;
        check("gate_after_seed", SW'(gate), SW'(0));
        step();
        // PERIOD blocks trigger a refetch
        repeat (4) begin
            done = 1;
            step();
            done = 0;
            step();
        end
        check("refetch_ready", SW'(tr), SW'(1));
        check("refetch_gate", SW'(gate), SW'(1));
        // Stalled offer with blocks in flight
        tv = 1;
        td = 80'hA5A5_0000_1111_2222_3333;
        step();
        tv = 0;
        for (int i = 0; i < 10; i++) begin
            done = (i == 2 || i == 6);
            step();
        end
        done = 0;
        check("inflight_cnt", SW'(cnt), SW'(6));
        orr = 1;
        step();
        orr = 0;
        check("clear_cnt", SW'(cnt), SW'(0));
        // Force together with a block, then repeated force in FETCH
        done = 1;
        step();
        done = 0;
        step();
        frc = 1;
        done = 1;
        step();
        done = 0;
        check("force_cnt", SW'(cnt), SW'(2));
        check("force_fetch", SW'(tr), SW'(1));
        repeat (3) step();
        frc = 0;
        tv = 1;
        td = 80'h1234_5678_9ABC_DEF0_0F0F;
        step();
        tv = 0;
        step();
        orr = 1;
        step();
        orr = 0;
        step();
        // Asynchronous reset while offering
        tv = 1;
        td = 80'hFFEE_DDCC_BBAA_9988_7766;
        step();
        tv = 0;
        step();
        #2 rst = 1;
        #1;
        check("arst_valid", SW'(ov), SW'(0));
        check("arst_data", od, '0);
        check("arst_seeded", SW'(sd), SW'(0));
        check("arst_ready", SW'(tr), SW'(1));
        step();
        rst = 0;
        step();
        // Saturation on the narrow counter instance
        s_tv = 1;
        s_td = 80'h77;
        step();
        s_tv = 0;
        step();
        check("sat_offer", SW'(s_ov), SW'(1));
        for (int k = 1; k <= 12; k++) begin
            s_done = 1;
            step();
            s_done = 0;
            check("sat_cnt", SW'(s_cnt), SW'(k < 7 ? k : 7));
        end
        check("sat_data", s_od, 80'h77);
        // Randomized traffic
        repeat (400) begin
            tv = ($urandom % 3) == 0;
            td = SW'({$urandom, $urandom, $urandom});
            orr = $urandom % 2;
            done = $urandom % 2;
            frc = ($urandom % 8) == 0;
            step();
        end
        tv = 0;
        orr = 0;
        done = 0;
        frc = 0;
        step();
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
